regfile_read_port: RTL and testbench

- Multi-entry register bank built from the team's 16-bit enabled-register pattern.
- Adds the missing read side: a valid/ready read-request channel and a registered two-operand response channel.
- Sits between the instruction-decode stage (issues operand reads) and the execute stage (consumes operands).
- Write port behaves exactly like the plain register: capture on clock edge when enabled.

---
 rtl/regfile_read_port.sv | 86 ++++++++
 tb/tb_regfile_read_port.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_port.sv
// Register bank with an enabled write port and a valid/ready operand-read channel.
// Reads return a registered two-operand response one cycle after the request is accepted.
module regfile_read_port #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  w_enable,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  localparam logic StEmpty = 1'b0;
  localparam logic StFull  = 1'b1;

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic                  state_q;
  logic [DATA_WIDTH-1:0] data_a_q, data_b_q;
  logic [DATA_WIDTH-1:0] operand_a, operand_b;
  logic                  accept;
  logic                  write_ok;

  assign rd_req_ready = (state_q == StEmpty) || rd_rsp_ready;
  assign accept       = rd_req_valid && rd_req_ready;
  assign write_ok     = w_enable && !(ZERO_REG && (w_addr == '0));

  // Bypass makes a same-cycle write visible to the request being accepted.
  always_comb begin
    operand_a = regs_q[rd_addr_a];
    if (ZERO_REG && (rd_addr_a == '0)) begin
      operand_a = '0;
    end else if (w_enable && (w_addr == rd_addr_a)) begin
      operand_a = w_data;
    end
  end

  always_comb begin
    operand_b = regs_q[rd_addr_b];
    if (ZERO_REG && (rd_addr_b == '0)) begin
      operand_b = '0;
    end else if (w_enable && (w_addr == rd_addr_b)) begin
      operand_b = w_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write_ok) begin
      regs_q[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= StEmpty;
      data_a_q <= '0;
      data_b_q <= '0;
    end else if (accept) begin
      state_q  <= StFull;
      data_a_q <= operand_a;
      data_b_q <= operand_b;
    end else if (rd_rsp_ready) begin
      state_q  <= StEmpty;
    end
  end

  assign rd_rsp_valid = (state_q == StFull);
  assign rd_data_a    = data_a_q;
  assign rd_data_b    = data_b_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Self-checking bench for regfile_read_port: directed scenarios plus random traffic
// compared against a transaction-level model of the bank and response slot.
module tb_regfile_read_port;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        w_enable;
  logic [2:0]  w_addr;
  logic [15:0] w_data;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic        rd_rsp_valid;
  logic        rd_rsp_ready;
  logic [15:0] rd_data_a, rd_data_b;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: bank contents and the expected response slot.
  logic [15:0] mem [8];
  logic        exp_valid;
  logic [15:0] exp_a, exp_b;

  regfile_read_port #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(3),
    .ZERO_REG  (1'b1)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .w_enable    (w_enable),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_ready(rd_rsp_ready),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] operand(input logic [2:0] addr);
    if (addr == 3'd0) return 16'h0000;
    if (w_enable && (w_addr == addr)) return w_data;
    return mem[addr];
  endfunction

  // Advance the model with the current inputs, then step one clock and settle.
  task automatic cycle();
    logic        rdy;
    logic [15:0] oa, ob;
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
      exp_valid = 1'b0;
      exp_a = 16'h0000;
      exp_b = 16'h0000;
    end else begin
      rdy = !exp_valid || rd_rsp_ready;
      oa = operand(rd_addr_a);
      ob = operand(rd_addr_b);
      if (w_enable && (w_addr != 3'd0)) mem[w_addr] = w_data;
      if (rd_req_valid && rdy) begin
        exp_valid = 1'b1;
        exp_a = oa;
        exp_b = ob;
      end else if (rd_rsp_ready) begin
        exp_valid = 1'b0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset_n = 1'b1;
    w_enable = 1'b0;
    w_addr = 3'd0;
    w_data = 16'h0000;
    rd_req_valid = 1'b0;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    rd_rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    cycle();
    cycle();
    n_cmp++;
    if (rd_rsp_valid !== 1'b0 || rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b a=%h b=%h, required 0/0000/0000",
               rd_rsp_valid, rd_data_a, rd_data_b);
    end
    reset_n = 1'b1;
    rd_req_valid = 1'b1;
    rd_addr_a = 3'd3;
    rd_addr_b = 3'd5;
    cycle();
    rd_req_valid = 1'b0;
    n_cmp++;
    if (rd_rsp_valid !== 1'b1 || rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_read: valid=%b a=%h b=%h, required 1/0000/0000",
               rd_rsp_valid, rd_data_a, rd_data_b);
    end
    cycle();
    n_cmp++;
    if (rd_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drain: valid=%b, required 0", rd_rsp_valid);
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    w_enable = 1'b1;
    w_addr = 3'd2;
    w_data = 16'hBEEF;
    cycle();
    w_enable = 1'b0;
    rd_req_valid = 1'b1;
    rd_addr_a = 3'd2;
    rd_addr_b = 3'd2;
    cycle();
    rd_req_valid = 1'b0;
    n_cmp++;
    if (rd_rsp_valid !== 1'b1 || rd_data_a !== 16'hBEEF || rd_data_b !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL write_read: valid=%b a=%h b=%h, required 1/beef/beef",
               rd_rsp_valid, rd_data_a, rd_data_b);
    end
    cycle();
  endtask

  task automatic test_bypass_zero();
    idle_inputs();
    w_enable = 1'b1;
    w_addr = 3'd4;
    w_data = 16'h1234;
    rd_req_valid = 1'b1;
    rd_addr_a = 3'd4;
    rd_addr_b = 3'd0;
    cycle();
    idle_inputs();
    n_cmp++;
    if (rd_rsp_valid !== 1'b1 || rd_data_a !== 16'h1234 || rd_data_b !== 16'h0000) begin
      n_fail++;
      $display("FAIL bypass: valid=%b a=%h b=%h, required 1/1234/0000",
               rd_rsp_valid, rd_data_a, rd_data_b);
    end
    w_enable = 1'b1;
    w_addr = 3'd0;
    w_data = 16'hFFFF;
    cycle();
    w_enable = 1'b0;
    rd_req_valid = 1'b1;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd4;
    cycle();
    rd_req_valid = 1'b0;
    n_cmp++;
    if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h1234) begin
      n_fail++;
      $display("FAIL zero_reg: a=%h b=%h, required 0000/1234", rd_data_a, rd_data_b);
    end
    cycle();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    w_enable = 1'b1;
    w_addr = 3'd3;
    w_data = 16'hAAAA;
    cycle();
    w_enable = 1'b0;
    rd_req_valid = 1'b1;
    rd_addr_a = 3'd3;
    rd_addr_b = 3'd3;
    rd_rsp_ready = 1'b0;
    cycle();
    // Keep a different request pending and overwrite the entry while stalled.
    rd_addr_a = 3'd2;
    w_enable = 1'b1;
    w_data = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (rd_req_ready !== 1'b0 || rd_rsp_valid !== 1'b1 ||
          rd_data_a !== 16'hAAAA || rd_data_b !== 16'hAAAA) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: ready=%b valid=%b a=%h b=%h, required 0/1/aaaa/aaaa",
                 i, rd_req_ready, rd_rsp_valid, rd_data_a, rd_data_b);
      end
      cycle();
      w_enable = 1'b0;
    end
    rd_rsp_ready = 1'b1;
    rd_addr_a = 3'd3;
    #1;
    n_cmp++;
    if (rd_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: ready=%b, required 1", rd_req_ready);
    end
    cycle();
    rd_req_valid = 1'b0;
    n_cmp++;
    if (rd_rsp_valid !== 1'b1 || rd_data_a !== 16'h5555 || rd_data_b !== 16'h5555) begin
      n_fail++;
      $display("FAIL backpressure_new: valid=%b a=%h b=%h, required 1/5555/5555",
               rd_rsp_valid, rd_data_a, rd_data_b);
    end
    cycle();
  endtask

  task automatic test_throughput();
    logic [15:0] want_a, want_b;
    idle_inputs();
    for (int i = 1; i < 8; i++) begin
      w_enable = 1'b1;
      w_addr = 3'(i);
      w_data = 16'(i * 16'h0011);
      cycle();
    end
    w_enable = 1'b0;
    for (int i = 1; i < 8; i++) begin
      rd_req_valid = 1'b1;
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(8 - i);
      cycle();
      want_a = 16'(i * 16'h0011);
      want_b = 16'((8 - i) * 16'h0011);
      n_cmp++;
      if (rd_rsp_valid !== 1'b1 || rd_data_a !== want_a || rd_data_b !== want_b) begin
        n_fail++;
        $display("FAIL throughput[%0d]: valid=%b a=%h b=%h, required 1/%h/%h",
                 i, rd_rsp_valid, rd_data_a, rd_data_b, want_a, want_b);
      end
    end
    rd_req_valid = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      w_enable = $urandom_range(0, 1);
      w_addr = 3'($urandom_range(0, 7));
      w_data = 16'($urandom);
      rd_req_valid = ($urandom_range(0, 3) != 0);
      rd_addr_a = 3'($urandom_range(0, 7));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 3'($urandom_range(0, 7));
      rd_rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      n_cmp++;
      if (rd_req_ready !== (!exp_valid || rd_rsp_ready)) begin
        n_fail++;
        $display("FAIL random_ready[%0d]: ready=%b, required %b",
                 i, rd_req_ready, !exp_valid || rd_rsp_ready);
      end
      cycle();
      n_cmp++;
      if (rd_rsp_valid !== exp_valid || rd_data_a !== exp_a || rd_data_b !== exp_b) begin
        n_fail++;
        $display("FAIL random_rsp[%0d]: valid=%b a=%h b=%h, required %b/%h/%h",
                 i, rd_rsp_valid, rd_data_a, rd_data_b, exp_valid, exp_a, exp_b);
      end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    for (int i = 1; i < 8; i++) begin
      w_enable = 1'b1;
      w_addr = 3'(i);
      w_data = 16'hC000 | 16'(i);
      cycle();
    end
    w_enable = 1'b0;
    rd_req_valid = 1'b1;
    rd_addr_a = 3'd6;
    rd_addr_b = 3'd7;
    rd_rsp_ready = 1'b0;
    cycle();
    rd_req_valid = 1'b0;
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    n_cmp++;
    if (rd_rsp_valid !== 1'b0 || rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_state: valid=%b a=%h b=%h, required 0/0000/0000",
               rd_rsp_valid, rd_data_a, rd_data_b);
    end
    rd_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_req_valid = 1'b1;
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      cycle();
      n_cmp++;
      if (rd_rsp_valid !== 1'b1 || rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_mid_entry[%0d]: valid=%b a=%h b=%h, required 1/0000/0000",
                 i, rd_rsp_valid, rd_data_a, rd_data_b);
      end
    end
    idle_inputs();
    cycle();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    exp_valid = 1'b0;
    exp_a = 16'h0000;
    exp_b = 16'h0000;
    idle_inputs();
    #1;
    test_reset();
    test_write_read();
    test_bypass_zero();
    test_backpressure();
    test_throughput();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
